// File: rtl/wb_pkg.sv
// Shared definitions for the write-back queue.
//   DATA_W     : register data width
//   REG_W      : register index width (R0 is hard-wired zero)
//   wb_entry_t : one queued load result (live flag, destination, data)
package wb_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int NREGS  = 1 << REG_W;

    typedef struct packed {
        logic              live;  // cleared by a WAW squash; dead entries pop silently
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of wb_entry_t for the write-back queue.
// Ports:
//   clk, rst_n   : clock, async active-low reset (clears all entries)
//   push, din    : write din at the tail
//   pop          : retire the head entry
//   kill         : per-slot live-bit clear (WAW squash)
//   entries      : raw slot contents, for rd compare and pending mask
//   head         : entry at the read pointer
//   count        : occupied slots, dead ones included
//   full, empty  : occupancy flags
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_entry_t                    din,
    input  logic                         pop,
    input  logic [DEPTH-1:0]             kill,
    output wb_entry_t [DEPTH-1:0]        entries,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wptr, rptr;

    assign entries = mem;
    assign head    = mem[rptr];
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);

    // Live bits are only ever set for occupied slots: kill and pop clear
    // them, push sets them. That lets the pending mask ignore pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill[i]) mem[i].live <= 1'b0;
            if (pop) begin
                mem[rptr].live <= 1'b0;
                rptr           <= rptr + 1'b1;
            end
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back arbiter: merges ALU results and load results onto the single
// register-file write port, queueing loads that collide with ALU writes.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   alu_valid/alu_rd/alu_data      : unstallable ALU result
//   mem_valid/mem_ready/mem_rd/mem_data : load result handshake
//   enableWrite/RW/BusW            : registered register-file write port
//   pending                        : registers targeted by live queued loads
//   q_count                        : queue occupancy (dead entries included)
module wb_write_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [REG_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_W-1:0]       mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   enableWrite,
    output logic [REG_W-1:0]       RW,
    output logic [DATA_W-1:0]      BusW,
    output logic [NREGS-1:0]       pending,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t [DEPTH-1:0] entries;
    wb_entry_t             head, din;
    logic [DEPTH-1:0]      kill;
    logic                  full, empty;
    logic                  alu_issue, mem_acc, head_live, head_dead;
    logic                  bypass, squash_load, push, pop;
    logic                  issue;
    logic [REG_W-1:0]      issue_rd;
    logic [DATA_W-1:0]     issue_data;

    // No credit for a same-cycle pop: a full queue refuses loads this cycle.
    assign mem_ready = (q_count < CW'(DEPTH));

    assign mem_acc   = mem_valid && mem_ready;
    assign alu_issue = alu_valid && (alu_rd != '0);
    assign head_live = !empty && head.live;
    assign head_dead = !empty && !head.live;

    // A dead head leaves regardless of the ALU; a live one only when the
    // port is free.
    assign pop = head_dead || (head_live && !alu_issue);

    // Same-cycle load is older than the ALU result, so an ALU write to the
    // same rd makes the load redundant.
    assign squash_load = alu_issue && (mem_rd == alu_rd);
    assign bypass      = mem_acc && (mem_rd != '0) && empty && !alu_issue;
    assign push        = mem_acc && (mem_rd != '0) && !bypass && !squash_load;

    assign din = '{live: 1'b1, rd: mem_rd, data: mem_data};

    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++)
            kill[i] = alu_issue && entries[i].live && (entries[i].rd == alu_rd);
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entries[i].live) pending[entries[i].rd] = 1'b1;
    end

    always_comb begin
        issue      = 1'b0;
        issue_rd   = '0;
        issue_data = '0;
        if (alu_issue) begin
            issue      = 1'b1;
            issue_rd   = alu_rd;
            issue_data = alu_data;
        end else if (head_live) begin
            issue      = 1'b1;
            issue_rd   = head.rd;
            issue_data = head.data;
        end else if (bypass) begin
            issue      = 1'b1;
            issue_rd   = mem_rd;
            issue_data = mem_data;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .din     (din),
        .pop     (pop),
        .kill    (kill),
        .entries (entries),
        .head    (head),
        .count   (q_count),
        .full    (full),
        .empty   (empty)
    );

    // RW/BusW hold their last value while the strobe is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enableWrite <= 1'b0;
            RW          <= '0;
            BusW        <= '0;
        end else begin
            enableWrite <= issue;
            if (issue) begin
                RW   <= issue_rd;
                BusW <= issue_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alu_valid = 1'b0;
    logic [REG_W-1:0]  alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [REG_W-1:0]  mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              enableWrite;
    logic [REG_W-1:0]  RW;
    logic [DATA_W-1:0] BusW;
    logic [NREGS-1:0]  pending;
    logic [$clog2(DEPTH):0] q_count;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [REG_W-1:0] rd; logic [DATA_W-1:0] data; } wr_t;
    wr_t sb[$];

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .enableWrite(enableWrite), .RW(RW), .BusW(BusW),
        .pending(pending), .q_count(q_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] data);
        wr_t w;
        w.rd = rd; w.data = data;
        sb.push_back(w);
    endtask

    // Every write must match the scoreboard head; any write with nothing
    // expected is an error.
    task automatic check_write();
        wr_t w;
        if (enableWrite) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {29'd0, RW}, 32'hFFFF_FFFF);
            end else begin
                w = sb.pop_front();
                chk("wr_rd",   32'(RW),   32'(w.rd));
                chk("wr_data", 32'(BusW), 32'(w.data));
            end
        end
    endtask

    // Drive one cycle of inputs, clock, then check the resulting write.
    task automatic step(input logic av, input logic [REG_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input logic mv, input logic [REG_W-1:0] mrd, input logic [DATA_W-1:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        @(posedge clk);
        #1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        check_write();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [DATA_W-1:0] ld_data[$];
        logic [REG_W-1:0]  ld_rd[$];
        int                budget;

        // Reset state
        #2;
        chk("rst_en",      32'(enableWrite), 32'd0);
        chk("rst_rw",      32'(RW),          32'd0);
        chk("rst_busw",    32'(BusW),        32'd0);
        chk("rst_pending", 32'(pending),     32'd0);
        chk("rst_qcount",  32'(q_count),     32'd0);
        chk("rst_ready",   32'(mem_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Lone load with empty queue bypasses
        expect_wr(3'd4, 16'h1234);
        step(1'b0, '0, '0, 1'b1, 3'd4, 16'h1234);
        chk("byp_pending", 32'(pending), 32'd0);
        chk("byp_qcount",  32'(q_count), 32'd0);

        // ALU and load in same cycle: ALU first, load queued
        expect_wr(3'd5, 16'h0002);
        expect_wr(3'd6, 16'h0007);
        step(1'b1, 3'd5, 16'h0002, 1'b1, 3'd6, 16'h0007);
        chk("col_pending6", 32'(pending[6]), 32'd1);
        chk("col_qcount",   32'(q_count),    32'd1);
        idle();
        chk("col_pending_clr", 32'(pending), 32'd0);
        chk("col_qcount0",     32'(q_count), 32'd0);

        // Fill: ALU busy 6 cycles, loads offered each cycle
        for (int i = 0; i < 6; i++) begin
            chk("fill_ready", 32'(mem_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            if (i < DEPTH) begin
                ld_rd.push_back(REG_W'((i % 3) + 2));
                ld_data.push_back(DATA_W'(16'h0200 + i));
            end
            expect_wr(3'd1, DATA_W'(16'h0100 + i));
            step(1'b1, 3'd1, DATA_W'(16'h0100 + i), 1'b1, REG_W'((i % 3) + 2), DATA_W'(16'h0200 + i));
        end
        chk("full_qcount", 32'(q_count),   32'd4);
        chk("full_ready",  32'(mem_ready), 32'd0);
        chk("full_pending", 32'(pending),  32'b0001_1100);
        while (ld_rd.size() > 0) expect_wr(ld_rd.pop_front(), ld_data.pop_front());
        // Head pops this edge but the offered load must still be refused
        step(1'b0, '0, '0, 1'b1, 3'd7, 16'hDEAD);
        chk("drain_qcount3", 32'(q_count),   32'd3);
        chk("drain_ready",   32'(mem_ready), 32'd1);
        budget = 10;
        while (q_count != 0 && budget > 0) begin
            idle();
            budget--;
        end
        chk("drain_done", 32'(q_count), 32'd0);
        chk("drain_sb",   32'(sb.size()), 32'd0);

        // WAW squash: queued load to R3 killed by later ALU write to R3
        expect_wr(3'd1, 16'h0011);
        step(1'b1, 3'd1, 16'h0011, 1'b1, 3'd3, 16'hAAAA);
        chk("sq_pending_set", 32'(pending[3]), 32'd1);
        chk("sq_qcount1",     32'(q_count),    32'd1);
        expect_wr(3'd3, 16'h5555);
        step(1'b1, 3'd3, 16'h5555, 1'b0, '0, '0);
        chk("sq_pending_clr", 32'(pending[3]), 32'd0);
        chk("sq_qcount_dead", 32'(q_count),    32'd1);
        idle();
        chk("sq_dead_nowrite", 32'(enableWrite), 32'd0);
        chk("sq_qcount0",      32'(q_count),     32'd0);

        // Same-cycle load to the ALU's rd is dropped
        expect_wr(3'd2, 16'h0B0B);
        step(1'b1, 3'd2, 16'h0B0B, 1'b1, 3'd2, 16'h0C0C);
        chk("sq_same_qcount", 32'(q_count), 32'd0);
        idle();
        chk("sq_same_nowrite", 32'(enableWrite), 32'd0);

        // rd=0 from both producers: nothing written or queued
        step(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 16'hEEEE);
        chk("r0_en",      32'(enableWrite), 32'd0);
        chk("r0_qcount",  32'(q_count),     32'd0);
        chk("r0_pending", 32'(pending),     32'd0);

        // Queue 3 entries, then asynchronous reset
        for (int i = 0; i < 3; i++) begin
            expect_wr(3'd1, DATA_W'(16'h0300 + i));
            step(1'b1, 3'd1, DATA_W'(16'h0300 + i), 1'b1, REG_W'(i + 2), DATA_W'(16'h0400 + i));
        end
        chk("pre_rst_qcount", 32'(q_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en",      32'(enableWrite), 32'd0);
        chk("arst_rw",      32'(RW),          32'd0);
        chk("arst_busw",    32'(BusW),        32'd0);
        chk("arst_pending", 32'(pending),     32'd0);
        chk("arst_qcount",  32'(q_count),     32'd0);
        chk("arst_ready",   32'(mem_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("post_rst_nowrite", 32'(enableWrite), 32'd0);
        end
        expect_wr(3'd5, 16'h0055);
        step(1'b0, '0, '0, 1'b1, 3'd5, 16'h0055);
        chk("post_rst_en", 32'(enableWrite), 32'd1);
        idle();
        chk("end_sb", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
